kernel_sched: RTL and testbench
===============================

# kernel_sched

Filter-switch controller for the convolution engine. Accepts kernel-select requests from the user-input logic and defers each change to the next frame boundary. At that boundary it streams the 25 coefficients of the selected kernel into the engine's coefficient registers over a valid/ready channel, then commits the matching divisor shift in a single cycle. It sits between the switch/button front end and the convolution datapath, and owns the only `kernel_ROM` instance.

## Interface
- `N_TAPS`, default `` `dwss `` (25): coefficients per kernel, row-major 5x5.
- `KW`, default `` `dwidth_kernel `` (8): coefficient width, two's complement.
- `DW`, default `` `dwidth_div ``: divisor (right-shift) width.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sel_req`  in  2  requested kernel: 00 passthrough, 01 Sobel, 10 blur, 11 sharpen.
- `sel_req_valid`  in  1  one-cycle strobe qualifying `sel_req`.
- `frame_start`  in  1  one-cycle pulse at start of vertical blank.
- `coef_ready`  in  1  engine accepts a coefficient this cycle.
- `coef_valid`  out  1  coefficient beat valid.
- `coef_data`  out  KW  coefficient value.
- `coef_idx`  out  5  tap index 0..N_TAPS-1; 0 = top-left, 24 = bottom-right.
- `div_out`  out  DW  divisor shift of the committed kernel.
- `active_sel`  out  2  committed kernel select.
- `commit`  out  1  one-cycle pulse; engine swaps shadow coefficients to live.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, PENDING, LOAD, COMMIT.
- **Reset:** state = PENDING, `pend_sel` = 00. The first frame therefore loads passthrough.
  - Output reset values: `coef_valid` = 0, `coef_data` = 0, `coef_idx` = 0, `div_out` = 0, `active_sel` = 00, `commit` = 0, `busy` = 1.
- **IDLE:**
  - `sel_req_valid` with `sel_req` != `active_sel`: latch `pend_sel`, go to PENDING.
  - `sel_req_valid` with `sel_req` == `active_sel`: ignored.
- **PENDING:**
  - `sel_req_valid` overwrites `pend_sel` (last request wins).
  - `frame_start`: copy `pend_sel` into `load_sel`, go to LOAD. If `sel_req_valid` arrives in the same cycle, `sel_req` is copied instead.
- **LOAD:**
  - `coef_data` = ROM kernel slice `[(N_TAPS-1-coef_idx)*KW +: KW]`; the ROM select is driven by `load_sel`, which is held stable for the whole state.
  - On each transfer (`coef_valid` && `coef_ready`), `coef_idx` increments.
  - Transfer at idx N_TAPS-1: deassert `coef_valid`, go to COMMIT.
  - `frame_start` is ignored in this state.
- **COMMIT:**
  - `commit` = 1 for one cycle; `div_out` = ROM div and `active_sel` = `load_sel`, both updated on the same edge.
  - Next state is PENDING if a deferred request exists and differs from the new `active_sel`; otherwise IDLE.
- **Requests during LOAD/COMMIT:** stored in a one-deep `next_sel` with `next_pend` flag; last request wins. The flag clears on leaving COMMIT.
- **Reset mid-LOAD:** the partial load is abandoned and no `commit` is issued. Outputs return to their reset values on the next edge.

## Timing
- All outputs are registered.
- `frame_start` at edge T in PENDING: `coef_valid` = 1 with idx 0 from T+1.
- With `coef_ready` held high: beats at T+1..T+25, `commit` at T+26, IDLE (`busy` = 0) at T+27.
- Each `coef_ready` low cycle adds one cycle of latency. `coef_data` and `coef_idx` stay stable while valid && !ready.
- Request to `commit` worst case: one frame plus 26 cycles plus backpressure.

## Structure
- `` `dwss ``, `` `dwidth_kernel ``, `` `dwidth_div `` and the select encodings (2'b00..2'b11) come from `my_header.vh`; this block adds localparam state encodings only.
- Sub-module: one `kernel_ROM` instance (combinational), select driven by `load_sel`.
- Everything else (FSM, index counter, request latches) stays in `kernel_sched`.

## Test plan
- **Reset release, ready high, `frame_start` at cycle 5:** 25 beats, idx 12 = 0x01 and all others 0x00; `commit` at cycle 31; `div_out` = 0; `active_sel` = 00.
- **Sobel load:** `sel_req` = 01 in IDLE, then `frame_start`. Required: idx 7 = 0x02, 8 = 0x02, 11 = 0xFE, 13 = 0x02, 16 = 0xFE, 17 = 0xFE, rest 0x00; `div_out` = 2.
- **Blur under backpressure:** `sel_req` = 10 with `coef_ready` toggling 1/0. Required: data held during stalls; idx 12 = 0x24; `commit` at T+50; `div_out` = 8.
- **Last-wins / same-select:** requests 11 then 01 while PENDING → Sobel loaded. Request 01 while `active_sel` = 01 in IDLE → `busy` stays 0.
- **Deferred request:** `sel_req` = 11 during LOAD of 10. Required: blur commits, state goes to PENDING, next `frame_start` loads sharpen (idx 12 = 0x1F, idx 7 = 0xFE, `div_out` = 4).
- **Reset mid-LOAD:** `rst_n` low at beat 10. Required: no `commit`; `coef_valid` = 0 next edge; next `frame_start` reloads passthrough.

Source files
------------

// File: rtl/kernel_sched_pkg.sv
// Shared constants for the kernel scheduler: tap geometry, widths,
// kernel select encodings and FSM state encoding.
package kernel_sched_pkg;

    localparam int DWSS          = 25;
    localparam int DWIDTH_KERNEL = 8;
    localparam int DWIDTH_DIV    = 4;

    localparam logic [1:0] SEL_PASS  = 2'b00;
    localparam logic [1:0] SEL_SOBEL = 2'b01;
    localparam logic [1:0] SEL_BLUR  = 2'b10;
    localparam logic [1:0] SEL_SHARP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOAD    = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/kernel_sched_rom.sv
// Combinational 5x5 kernel ROM. Tap 0 (top-left) sits in the MSB byte,
// so tap i lives at [(DWSS-1-i)*KW +: KW].
module kernel_ROM
    import kernel_sched_pkg::*;
(
    input  logic [1:0]                      i_sel,
    output logic [DWSS*DWIDTH_KERNEL-1:0]   o_kernel,
    output logic [DWIDTH_DIV-1:0]           o_div
);

    localparam logic [DWSS*DWIDTH_KERNEL-1:0] K_PASS = {
        {12{8'h00}}, 8'h01, {12{8'h00}}
    };

    localparam logic [DWSS*DWIDTH_KERNEL-1:0] K_SOBEL = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h02, 8'h02, 8'h00,
        8'h00, 8'hFE, 8'h00, 8'h02, 8'h00,
        8'h00, 8'hFE, 8'hFE, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // 5x5 binomial (Gaussian) kernel, sums to 256
    localparam logic [DWSS*DWIDTH_KERNEL-1:0] K_BLUR = {
        8'h01, 8'h04, 8'h06, 8'h04, 8'h01,
        8'h04, 8'h10, 8'h18, 8'h10, 8'h04,
        8'h06, 8'h18, 8'h24, 8'h18, 8'h06,
        8'h04, 8'h10, 8'h18, 8'h10, 8'h04,
        8'h01, 8'h04, 8'h06, 8'h04, 8'h01
    };

    localparam logic [DWSS*DWIDTH_KERNEL-1:0] K_SHARP = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'hFF, 8'hFE, 8'hFF, 8'h00,
        8'h00, 8'hFE, 8'h1F, 8'hFE, 8'h00,
        8'h00, 8'hFF, 8'hFE, 8'hFF, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    always_comb begin
        o_kernel = K_PASS;
        o_div    = 4'd0;
        unique case (i_sel)
            SEL_PASS: begin
                o_kernel = K_PASS;
                o_div    = 4'd0;
            end
            SEL_SOBEL: begin
                o_kernel = K_SOBEL;
                o_div    = 4'd2;
            end
            SEL_BLUR: begin
                o_kernel = K_BLUR;
                o_div    = 4'd8;
            end
            SEL_SHARP: begin
                o_kernel = K_SHARP;
                o_div    = 4'd4;
            end
        endcase
    end

endmodule

// File: rtl/kernel_sched.sv
// Defers kernel-select changes to the frame boundary, streams the new
// coefficients to the engine, then commits the divisor in one cycle.
module kernel_sched
    import kernel_sched_pkg::*;
#(
    parameter int N_TAPS = DWSS,
    parameter int KW     = DWIDTH_KERNEL,
    parameter int DW     = DWIDTH_DIV
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    sel_req,
    input  logic          sel_req_valid,
    input  logic          frame_start,
    input  logic          coef_ready,
    output logic          coef_valid,
    output logic [KW-1:0] coef_data,
    output logic [4:0]    coef_idx,
    output logic [DW-1:0] div_out,
    output logic [1:0]    active_sel,
    output logic          commit,
    output logic          busy
);

    state_t r_state, w_state_nxt;

    logic [1:0]    r_pend_sel, w_pend_nxt;
    logic [1:0]    r_load_sel, w_load_nxt;
    logic [1:0]    r_next_sel, w_next_sel_nxt;
    logic          r_next_pend, w_next_pend_nxt;
    logic [4:0]    r_idx, w_idx_nxt;
    logic          r_valid, w_valid_nxt;
    logic [DW-1:0] r_div, w_div_nxt;
    logic [1:0]    r_active, w_active_nxt;
    logic          r_commit, w_commit_nxt;

    logic [N_TAPS*KW-1:0] w_kernel;
    logic [DW-1:0]        w_rom_div;
    logic [KW-1:0]        w_coef;
    logic                 w_xfer;
    logic                 w_has_req;
    logic [1:0]           w_req_sel;

    kernel_ROM u_rom (
        .i_sel    (r_load_sel),
        .o_kernel (w_kernel),
        .o_div    (w_rom_div)
    );

    assign w_xfer = r_valid & coef_ready;

    // A request arriving in the COMMIT cycle itself still counts as deferred
    assign w_has_req = sel_req_valid | r_next_pend;
    assign w_req_sel = sel_req_valid ? sel_req : r_next_sel;

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = r_pend_sel;
        w_load_nxt      = r_load_sel;
        w_next_sel_nxt  = r_next_sel;
        w_next_pend_nxt = r_next_pend;
        w_idx_nxt       = r_idx;
        w_valid_nxt     = r_valid;
        w_div_nxt       = r_div;
        w_active_nxt    = r_active;
        w_commit_nxt    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (sel_req_valid && sel_req != r_active) begin
                    w_pend_nxt  = sel_req;
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (sel_req_valid)
                    w_pend_nxt = sel_req;
                if (frame_start) begin
                    w_load_nxt  = sel_req_valid ? sel_req : r_pend_sel;
                    w_idx_nxt   = 5'd0;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (sel_req_valid) begin
                    w_next_sel_nxt  = sel_req;
                    w_next_pend_nxt = 1'b1;
                end
                if (w_xfer) begin
                    if (r_idx == 5'(N_TAPS - 1)) begin
                        w_idx_nxt    = 5'd0;
                        w_valid_nxt  = 1'b0;
                        w_commit_nxt = 1'b1;
                        w_div_nxt    = w_rom_div;
                        w_active_nxt = r_load_sel;
                        w_state_nxt  = ST_COMMIT;
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end
            end
            ST_COMMIT: begin
                w_next_pend_nxt = 1'b0;
                if (w_has_req && w_req_sel != r_active) begin
                    w_pend_nxt  = w_req_sel;
                    w_state_nxt = ST_PENDING;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_PENDING;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_sel  <= SEL_PASS;
            r_load_sel  <= SEL_PASS;
            r_next_sel  <= SEL_PASS;
            r_next_pend <= 1'b0;
            r_idx       <= 5'd0;
            r_valid     <= 1'b0;
            r_div       <= '0;
            r_active    <= SEL_PASS;
            r_commit    <= 1'b0;
        end else begin
            r_pend_sel  <= w_pend_nxt;
            r_load_sel  <= w_load_nxt;
            r_next_sel  <= w_next_sel_nxt;
            r_next_pend <= w_next_pend_nxt;
            r_idx       <= w_idx_nxt;
            r_valid     <= w_valid_nxt;
            r_div       <= w_div_nxt;
            r_active    <= w_active_nxt;
            r_commit    <= w_commit_nxt;
        end
    end

    // Data is a pure function of registered state; forced to 0 off-beat
    always_comb begin
        w_coef = '0;
        if (r_valid)
            w_coef = w_kernel[(N_TAPS - 1 - int'(r_idx)) * KW +: KW];
    end

    assign coef_valid = r_valid;
    assign coef_data  = w_coef;
    assign coef_idx   = r_idx;
    assign div_out    = r_div;
    assign active_sel = r_active;
    assign commit     = r_commit;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_kernel_sched.sv
// Directed bench for kernel_sched: expected coefficient beats are queued
// when a load is launched and popped as the engine accepts each beat.
module tb_kernel_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel_req;
    logic       sel_req_valid;
    logic       frame_start;
    logic       coef_ready;
    logic       coef_valid;
    logic [7:0] coef_data;
    logic [4:0] coef_idx;
    logic [3:0] div_out;
    logic [1:0] active_sel;
    logic       commit;
    logic       busy;

    always #5 clk = ~clk;

    kernel_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel_req       (sel_req),
        .sel_req_valid (sel_req_valid),
        .frame_start   (frame_start),
        .coef_ready    (coef_ready),
        .coef_valid    (coef_valid),
        .coef_data     (coef_data),
        .coef_idx      (coef_idx),
        .div_out       (div_out),
        .active_sel    (active_sel),
        .commit        (commit),
        .busy          (busy)
    );

    typedef struct {
        logic [4:0] idx;
        logic [7:0] data;
        bit         chk;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Only taps the kernel definition pins down are marked for checking
    task automatic push_exp(input logic [1:0] ksel);
        beat_t b;
        for (int i = 0; i < 25; i++) begin
            b.idx  = 5'(i);
            b.data = 8'h00;
            b.chk  = 1'b1;
            case (ksel)
                2'b00: b.data = (i == 12) ? 8'h01 : 8'h00;
                2'b01: begin
                    if (i == 7 || i == 8 || i == 13)
                        b.data = 8'h02;
                    else if (i == 11 || i == 16 || i == 17)
                        b.data = 8'hFE;
                end
                2'b10: begin
                    b.chk  = (i == 12);
                    b.data = 8'h24;
                end
                default: begin
                    b.chk  = (i == 12) || (i == 7);
                    b.data = (i == 12) ? 8'h1F : 8'hFE;
                end
            endcase
            sb.push_back(b);
        end
    endtask

    task automatic run_load(input logic [1:0] ksel, input bit bp,
                            input bit defer, input int abort_at,
                            input int exp_lat, input logic [3:0] exp_div);
        int    n;
        int    beats;
        int    vcyc;
        bit    done;
        bit    prev_stall;
        bit    rdy;
        logic [7:0] pd;
        logic [4:0] pi;
        beat_t b;
        sb.delete();
        push_exp(ksel);
        n = 0; beats = 0; vcyc = 0; done = 0; prev_stall = 0;
        pd = '0; pi = '0;
        @(negedge clk);
        frame_start = 1'b1;
        coef_ready  = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            frame_start   = 1'b0;
            sel_req_valid = 1'b0;
            if (abort_at >= 0 && beats == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("abort_valid", 32'(coef_valid), 32'd0);
                chk("abort_commit", 32'(commit), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("abort_no_commit", 32'(commit), 32'd0);
                end
                rst_n = 1'b1;
                sb.delete();
                done = 1'b1;
            end else if (commit) begin
                chk("commit_latency", 32'(n), 32'(exp_lat));
                chk("div_out", 32'(div_out), 32'(exp_div));
                chk("active_sel", 32'(active_sel), 32'(ksel));
                chk("sb_drained", 32'(sb.size()), 32'd0);
                chk("valid_off_at_commit", 32'(coef_valid), 32'd0);
                done = 1'b1;
            end else if (coef_valid) begin
                if (prev_stall) begin
                    chk("stall_data", 32'(coef_data), 32'(pd));
                    chk("stall_idx", 32'(coef_idx), 32'(pi));
                end
                rdy = bp ? (vcyc % 2 == 0) : 1'b1;
                coef_ready = rdy;
                vcyc++;
                if (rdy) begin
                    if (sb.size() == 0) begin
                        chk("extra_beat", 32'(sb.size()), 32'd1);
                    end else begin
                        b = sb.pop_front();
                        chk("beat_idx", 32'(coef_idx), 32'(b.idx));
                        if (b.chk)
                            chk("beat_data", 32'(coef_data), 32'(b.data));
                    end
                    beats++;
                end
                prev_stall = !rdy;
                pd = coef_data;
                pi = coef_idx;
            end else begin
                chk("valid_during_load", 32'(coef_valid), 32'd1);
            end
            if (defer && n == 5) begin
                sel_req       = 2'b11;
                sel_req_valid = 1'b1;
            end
            if (n == 8)
                frame_start = 1'b1;
        end
        if (!done)
            chk("load_timeout", 32'(done), 32'd1);
        coef_ready = 1'b1;
    endtask

    task automatic request(input logic [1:0] s);
        @(negedge clk);
        sel_req       = s;
        sel_req_valid = 1'b1;
        @(negedge clk);
        sel_req_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        sel_req       = 2'b00;
        sel_req_valid = 1'b0;
        frame_start   = 1'b0;
        coef_ready    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(coef_valid), 32'd0);
        chk("rst_data", 32'(coef_data), 32'd0);
        chk("rst_idx", 32'(coef_idx), 32'd0);
        chk("rst_div", 32'(div_out), 32'd0);
        chk("rst_active", 32'(active_sel), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("pending_busy", 32'(busy), 32'd1);
        chk("pending_no_valid", 32'(coef_valid), 32'd0);

        run_load(2'b00, 1'b0, 1'b0, -1, 26, 4'd0);
        @(negedge clk);
        chk("pass_idle", 32'(busy), 32'd0);

        request(2'b01);
        chk("sobel_pending", 32'(busy), 32'd1);
        run_load(2'b01, 1'b0, 1'b0, -1, 26, 4'd2);
        @(negedge clk);
        chk("sobel_idle", 32'(busy), 32'd0);

        request(2'b01);
        @(negedge clk);
        chk("same_sel_ignored", 32'(busy), 32'd0);

        request(2'b11);
        request(2'b01);
        chk("lastwins_pending", 32'(busy), 32'd1);
        run_load(2'b01, 1'b0, 1'b0, -1, 26, 4'd2);
        @(negedge clk);
        chk("lastwins_idle", 32'(busy), 32'd0);

        request(2'b10);
        run_load(2'b10, 1'b1, 1'b1, -1, 50, 4'd8);
        @(negedge clk);
        chk("defer_pending", 32'(busy), 32'd1);
        chk("commit_one_cycle", 32'(commit), 32'd0);
        chk("blur_active", 32'(active_sel), 32'd2);
        run_load(2'b11, 1'b0, 1'b0, -1, 26, 4'd4);
        @(negedge clk);
        chk("sharp_idle", 32'(busy), 32'd0);

        request(2'b10);
        run_load(2'b10, 1'b0, 1'b0, 10, 0, 4'd0);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd1);
        chk("post_rst_active", 32'(active_sel), 32'd0);
        chk("post_rst_div", 32'(div_out), 32'd0);
        run_load(2'b00, 1'b0, 1'b0, -1, 26, 4'd0);
        @(negedge clk);
        chk("reload_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
